// File: rtl/mux16_1_scanner.sv
// Time-division 16:1 scanner: snapshots 16 channels and plays them out one per beat.
// Define MUX16_CONT_EN for continuous mode (re-capture and wrap with no gap cycle).
module mux16_1_scanner #(
  parameter int W     = 1,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            e,
  input  logic            start,
  input  logic [16*W-1:0] d,
  output logic [W-1:0]    y,
  output logic [3:0]      s,
  output logic            valid,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PAUSE
  } state_t;

  localparam logic [3:0] DW_LAST = 4'(DWELL - 1);

  state_t          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [3:0]      dwell_q, dwell_d;
  logic [16*W-1:0] shadow_q, shadow_d;
  logic [W-1:0]    y_q, y_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        s_d     = 4'd0;
        dwell_d = 4'd0;
        if (start && !e) begin
          shadow_d = d;
          state_d  = SCAN;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (e) begin
          state_d = PAUSE;
        end else if (dwell_q != DW_LAST) begin
          dwell_d = dwell_q + 4'd1;
          valid_d = 1'b1;
        end else begin
          dwell_d = 4'd0;
          s_d     = s_q + 4'd1;
          valid_d = 1'b1;
          if (s_q == 4'd15) begin
`ifdef MUX16_CONT_EN
            shadow_d = d;
`else
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            s_d     = 4'd0;
`endif
          end
        end
      end
      PAUSE: begin
        busy_d = 1'b1;
        if (!e) begin
          state_d = SCAN;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Outputs are computed from the next beat so they can be registered.
    y_d    = valid_d ? shadow_d[int'(s_d)*W +: W] : '0;
    done_d = valid_d && (s_d == 4'd15) && (dwell_d == DW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= 4'd0;
      dwell_q  <= 4'd0;
      shadow_q <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign y     = y_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mux16_1_scanner.sv
// Scoreboard bench for mux16_1_scanner: DWELL=1 and DWELL=3 instances.
// Expected beats are queued at stimulus time; a negedge monitor pops them.
module tb_mux16_1_scanner;

  logic        clk = 1'b0;
  logic        rst, e, start1, start3;
  logic [15:0] d;
  logic        y1, v1, b1, dn1;
  logic        y3, v3, b3, dn3;
  logic [3:0]  s1, s3;

  always #5 clk = ~clk;

  mux16_1_scanner #(.W(1), .DWELL(1)) u1 (
    .clk(clk), .rst(rst), .e(e), .start(start1), .d(d),
    .y(y1), .s(s1), .valid(v1), .busy(b1), .done(dn1)
  );

  mux16_1_scanner #(.W(1), .DWELL(3)) u3 (
    .clk(clk), .rst(rst), .e(e), .start(start3), .d(d),
    .y(y3), .s(s3), .valid(v3), .busy(b3), .done(dn3)
  );

  typedef logic [5:0] beat_t;
  beat_t q1[$];
  beat_t q3[$];
  beat_t act1, act3;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (v1 === 1'b1) begin
      act1 = {dn1, s1, y1};
      if (q1.size() == 0) chk("dut1 unexpected beat", act1, 16'hffff);
      else chk("dut1 beat {done,s,y}", act1, q1.pop_front());
    end else if (dn1 !== 1'b0) begin
      chk("dut1 done without valid", dn1, 0);
    end
    if (v3 === 1'b1) begin
      act3 = {dn3, s3, y3};
      if (q3.size() == 0) chk("dut3 unexpected beat", act3, 16'hffff);
      else chk("dut3 beat {done,s,y}", act3, q3.pop_front());
    end else if (dn3 !== 1'b0) begin
      chk("dut3 done without valid", dn3, 0);
    end
  end

  task automatic push_frame(input int dut, input logic [15:0] dv,
                            input int dwell, input int nbeats,
                            input int rep);
    beat_t bt;
    int    si, dw;
    for (int b = 0; b < nbeats; b++) begin
      si = b / dwell;
      dw = b % dwell;
      bt = {(si == 15 && dw == dwell - 1), 4'(si), dv[si]};
      if (dut == 1) q1.push_back(bt);
      else q3.push_back(bt);
      if (b == rep) begin
        if (dut == 1) q1.push_back(bt);
        else q3.push_back(bt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic a, input logic b);
    start1 = a;
    start3 = b;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_idle(input int dut, input int budget);
    int n = 0;
    while ((dut == 1 ? b1 : b3) && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("dut%0d frame ends in budget", dut),
        dut == 1 ? b1 : b3, 0);
  endtask

  initial begin
    rst = 1'b1; e = 1'b0; start1 = 1'b0; start3 = 1'b0; d = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset y1", y1, 0);   chk("reset s1", s1, 0);
    chk("reset v1", v1, 0);   chk("reset b1", b1, 0);
    chk("reset dn1", dn1, 0); chk("reset y3", y3, 0);
    chk("reset s3", s3, 0);   chk("reset v3", v3, 0);
    chk("reset b3", b3, 0);   chk("reset dn3", dn3, 0);

`ifdef MUX16_CONT_EN
    d = 16'h0001;
    push_frame(1, 16'h0001, 1, 16, -1);
    push_frame(1, 16'h8000, 1, 16, -1);
    push_frame(1, 16'h8000, 1, 16, -1);
    pulse_start(1'b1, 1'b0);
    d = 16'h8000;
    for (int b = 1; b < 48; b++) begin
      tick();
      if (b == 16) begin
        chk("cont wrap s", s1, 0);
        chk("cont wrap valid", v1, 1);
        chk("cont wrap busy", b1, 1);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cont rst busy", b1, 0);
    chk("cont rst valid", v1, 0);
`else
    // DWELL=1 frame
    d = 16'hA5C3;
    push_frame(1, 16'hA5C3, 1, 16, -1);
    pulse_start(1'b1, 1'b0);
    chk("dut1 first beat latency", v1, 1);
    wait_idle(1, 40);
    chk("dut1 idle s", s1, 0);
    chk("dut1 idle y", y1, 0);
    chk("dut1 idle valid", v1, 0);

    // DWELL=3, d cleared mid-frame, start at s=9 ignored
    push_frame(3, 16'hA5C3, 3, 48, -1);
    pulse_start(1'b0, 1'b1);
    for (int b = 1; b < 48; b++) begin
      tick();
      if (b == 5) d = 16'h0000;
      if (b == 27) begin
        chk("dut3 s at beat 27", s3, 9);
        start3 = 1'b1;
      end else begin
        start3 = 1'b0;
      end
      if (b == 10) chk("dut3 busy mid-frame", b3, 1);
    end
    wait_idle(3, 10);
    chk("dut3 idle s", s3, 0);

    // pause at s=6, dwell=1
    d = 16'hA5C3;
    push_frame(3, 16'hA5C3, 3, 48, 19);
    pulse_start(1'b0, 1'b1);
    for (int b = 1; b < 20; b++) tick();
    e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pause valid", v3, 0);
      chk("pause busy", b3, 1);
      chk("pause s held", s3, 6);
      chk("pause y", y3, 0);
    end
    e = 1'b0;
    wait_idle(3, 100);

    // start while paused-enable is high is dropped
    e = 1'b1;
    pulse_start(1'b1, 1'b1);
    e = 1'b0;
    tick();
    tick();
    chk("e=1 start v1", v1, 0); chk("e=1 start b1", b1, 0);
    chk("e=1 start v3", v3, 0); chk("e=1 start b3", b3, 0);

    // reset mid-frame at s=10, then restart from s=0
    push_frame(3, 16'hA5C3, 3, 31, -1);
    pulse_start(1'b0, 1'b1);
    for (int b = 1; b < 31; b++) tick();
    chk("dut3 s before rst", s3, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid y", y3, 0);   chk("rst mid s", s3, 0);
    chk("rst mid v", v3, 0);   chk("rst mid busy", b3, 0);
    chk("rst mid done", dn3, 0);
    d = 16'h1234;
    push_frame(3, 16'h1234, 3, 48, -1);
    tick();
    pulse_start(1'b0, 1'b1);
    chk("restart s", s3, 0);
    wait_idle(3, 60);
`endif

    tick();
    chk("dut1 queue drained", 16'(q1.size()), 0);
    chk("dut3 queue drained", 16'(q3.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
